// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulus counter family.
package counter_pkg;

  localparam logic CNT_MODE_WRAP = 1'b0;
  localparam logic CNT_MODE_SAT  = 1'b1;
  localparam logic CNT_UP        = 1'b1;

endpackage

// File: rtl/updown_mod_next.sv
// Combinational next-count and boundary-event logic for one up/down modulus step.
module updown_mod_next
  import counter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] count,
  input  logic [N-1:0] modulus,
  input  logic         upDown,
  input  logic         mode,
  output logic [N-1:0] next_count,
  output logic         boundary
);

  always_comb begin
    next_count = count;
    boundary   = 1'b0;
    if (upDown == CNT_UP) begin
      if (count < modulus) begin
        next_count = count + N'(1);
      end else begin
        boundary   = 1'b1;
        next_count = (mode == CNT_MODE_SAT) ? modulus : '0;
      end
    end else if (count > modulus) begin
      // Only reachable after modulus was lowered below the current count.
      next_count = modulus;
    end else if (count != '0) begin
      next_count = count - N'(1);
    end else begin
      boundary   = 1'b1;
      next_count = (mode == CNT_MODE_SAT) ? '0 : modulus;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Pausable up/down counter with run-time modulus, wrap/saturate mode, parallel load
// and a registered terminal-count pulse for cascading.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter logic        SATURATE  = CNT_MODE_WRAP,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pause,
  input  logic         upDown,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] modulus,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [N-1:0] RstCount = N'(RESET_VAL);

  logic [N-1:0] step_count;
  logic         step_boundary;
  logic [N-1:0] load_clamped;
  logic [N-1:0] count_d;
  logic         tc_d;

  updown_mod_next #(
    .N(N)
  ) u_next (
    .count      (count),
    .modulus    (modulus),
    .upDown     (upDown),
    .mode       (SATURATE),
    .next_count (step_count),
    .boundary   (step_boundary)
  );

  assign load_clamped = (load_val > modulus) ? modulus : load_val;

  always_comb begin
    count_d = count;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (!pause) begin
      count_d = step_count;
      tc_d    = step_boundary;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RstCount;
      tc    <= 1'b0;
    end else begin
      count <= count_d;
      tc    <= tc_d;
    end
  end

  assign at_max = (count == modulus);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Checks a wrap-mode and a saturate-mode counter side by side against an integer model.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic       upDown;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] modulus;

  logic [3:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, amax_w, amax_s, amin_w, amin_s;

  int errors = 0;
  int checks = 0;
  int mc[2];
  int mt[2];

  always #5 clk = ~clk;

  updown_mod_counter #(.N(4), .SATURATE(1'b0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .reset(reset), .pause(pause), .upDown(upDown), .load(load),
    .load_val(load_val), .modulus(modulus), .count(cnt_w), .tc(tc_w),
    .at_max(amax_w), .at_min(amin_w)
  );

  updown_mod_counter #(.N(4), .SATURATE(1'b1), .RESET_VAL(0)) u_sat (
    .clk(clk), .reset(reset), .pause(pause), .upDown(upDown), .load(load),
    .load_val(load_val), .modulus(modulus), .count(cnt_s), .tc(tc_s),
    .at_max(amax_s), .at_min(amin_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: one enabled edge for counter i (0 = wrap, 1 = saturate), integer arithmetic.
  function automatic void mstep(input int i);
    int m;
    m = int'(modulus);
    if (load) begin
      mc[i] = (int'(load_val) < m) ? int'(load_val) : m;
      mt[i] = 0;
    end else if (pause) begin
      mt[i] = 0;
    end else if (upDown) begin
      if (mc[i] < m) begin
        mc[i]++;
        mt[i] = 0;
      end else begin
        mc[i] = (i == 1) ? m : 0;
        mt[i] = 1;
      end
    end else begin
      if (mc[i] > m) begin
        mc[i] = m;
        mt[i] = 0;
      end else if (mc[i] > 0) begin
        mc[i]--;
        mt[i] = 0;
      end else begin
        mc[i] = (i == 1) ? 0 : m;
        mt[i] = 1;
      end
    end
  endfunction

  function automatic void mreset();
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0;
      mt[i] = 0;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_w_count"}, int'(cnt_w), mc[0]);
    chk({tag, "_w_tc"}, int'(tc_w), mt[0]);
    chk({tag, "_w_atmax"}, int'(amax_w), int'(mc[0] == int'(modulus)));
    chk({tag, "_w_atmin"}, int'(amin_w), int'(mc[0] == 0));
    chk({tag, "_s_count"}, int'(cnt_s), mc[1]);
    chk({tag, "_s_tc"}, int'(tc_s), mt[1]);
    chk({tag, "_s_atmax"}, int'(amax_s), int'(mc[1] == int'(modulus)));
    chk({tag, "_s_atmin"}, int'(amin_s), int'(mc[1] == 0));
  endtask

  // Inputs are changed 1ns after the edge, so they are stable for the next edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset) begin
      mstep(0);
      mstep(1);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    reset    = 1'b1;
    pause    = 1'b0;
    upDown   = 1'b1;
    load     = 1'b0;
    load_val = '0;
    modulus  = 4'd9;
    mreset();
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Up wrap from 0 with modulus 9
    for (int k = 1; k <= 9; k++) tick("upwrap");
    chk("upwrap_9_count", int'(cnt_w), 9);
    chk("upwrap_9_atmax", int'(amax_w), 1);
    chk("upwrap_9_tc", int'(tc_w), 0);
    tick("upwrap10");
    chk("upwrap_10_count", int'(cnt_w), 0);
    chk("upwrap_10_tc", int'(tc_w), 1);
    chk("sat_pinned_tc", int'(tc_s), 1);
    tick("upwrap11");
    chk("upwrap_11_count", int'(cnt_w), 1);
    chk("upwrap_11_tc", int'(tc_w), 0);

    // Asynchronous reset between edges while count = 6
    load = 1'b1;
    load_val = 4'd6;
    tick("load6");
    load = 1'b0;
    pause = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    mreset();
    #1;
    chk("async_rst_count", int'(cnt_w), 0);
    chk("async_rst_tc", int'(tc_w), 0);
    pause = 1'b0;
    tick("rst_held");
    #2;
    reset = 1'b0;
    tick("rst_release");
    chk("rst_first_step", int'(cnt_w), 1);

    // Down wrap: 2, 1, 0, 9
    load = 1'b1;
    load_val = 4'd2;
    tick("dn_load");
    chk("dn_load_count", int'(cnt_w), 2);
    load = 1'b0;
    upDown = 1'b0;
    tick("dn1");
    tick("dn0");
    chk("dn_0_atmin", int'(amin_w), 1);
    chk("dn_0_tc", int'(tc_w), 0);
    tick("dn9");
    chk("dn_wrap_count", int'(cnt_w), 9);
    chk("dn_wrap_tc", int'(tc_w), 1);

    // Saturate at 15
    modulus = 4'd15;
    upDown = 1'b1;
    load = 1'b1;
    load_val = 4'd14;
    tick("sat_load");
    load = 1'b0;
    tick("sat15");
    chk("sat_15_count", int'(cnt_s), 15);
    chk("sat_15_tc", int'(tc_s), 0);
    tick("sat_pin1");
    tick("sat_pin2");
    chk("sat_pin_count", int'(cnt_s), 15);
    chk("sat_pin_tc", int'(tc_s), 1);
    pause = 1'b1;
    tick("sat_pause");
    chk("sat_pause_tc", int'(tc_s), 0);
    chk("sat_pause_count", int'(cnt_s), 15);

    // Load beats pause and is clamped to modulus
    modulus = 4'd9;
    load = 1'b1;
    load_val = 4'd12;
    tick("ld_clamp");
    chk("ld_clamp_count", int'(cnt_w), 9);
    load = 1'b0;
    for (int k = 0; k < 3; k++) tick("ld_hold");
    chk("ld_hold_count", int'(cnt_w), 9);
    modulus = 4'd5;
    pause = 1'b0;
    upDown = 1'b0;
    tick("mod_lower");
    chk("mod_lower_count", int'(cnt_w), 5);
    chk("mod_lower_tc", int'(tc_w), 0);

    // Direction flip at the bound
    modulus = 4'd9;
    load = 1'b1;
    load_val = 4'd9;
    upDown = 1'b1;
    tick("flip_load");
    load = 1'b0;
    upDown = 1'b0;
    tick("flip");
    chk("flip_count", int'(cnt_w), 8);
    chk("flip_tc", int'(tc_w), 0);

    // modulus 0: every enabled edge is a boundary event
    modulus = 4'd0;
    upDown = 1'b1;
    for (int k = 0; k < 3; k++) tick("mod0");
    chk("mod0_count", int'(cnt_w), 0);
    chk("mod0_tc", int'(tc_w), 1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      load = (r < 8);
      pause = (r >= 8 && r < 20);
      upDown = 1'($urandom_range(0, 1));
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) modulus = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        mreset();
        #1;
        check_all("rnd_rst");
        #1;
        reset = 1'b0;
      end
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
